// File: rtl/dec_exe_pipe_pkg.sv
// Shared definitions for the DEC-to-EXE pipeline register: default widths,
// bubble encodings and the per-cycle action selection.
package dec_exe_pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int UOP_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  // A bubble carries an all-zero control bundle and targets x0.
  localparam logic [UOP_W_DEF-1:0] UOP_BUBBLE = '0;
  localparam logic [4:0]           REG_X0     = 5'd0;

  // What the EXE register does on the next rising edge (reset handled apart).
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_HOLD    = 2'd3
  } pipe_act_e;

  // Priority: hold > flush > stall > capture.
  function automatic pipe_act_e pick_action(input logic hold, input logic flush,
                                            input logic stall);
    pipe_act_e act;
    act = ACT_CAPTURE;
    if (hold)       act = ACT_HOLD;
    else if (flush) act = ACT_FLUSH;
    else if (stall) act = ACT_STALL;
    return act;
  endfunction

endpackage

// File: rtl/dec_exe_pipe_if.sv
// DEC/EXE boundary bundle: DEC-side request, EXE-side registered view,
// hold feedback and performance counters.
interface dec_exe_pipe_if
  import dec_exe_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int UOP_W = UOP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();
  logic             dec_valid;
  logic [XLEN-1:0]  dec_pc;
  logic [UOP_W-1:0] dec_uop;
  logic [XLEN-1:0]  dec_imm;
  logic [4:0]       dec_rd;
  logic             dec_rd_wenb;
  logic             dec_load;
  logic             dec_csr;
  logic [XLEN-1:0]  dec_rs1_data;
  logic [XLEN-1:0]  dec_rs2_data;
  logic             dec_stall;
  logic             dec_load_use;
  logic             dec_csr_use;
  logic             exe_flush;
  logic             exe_hold;
  logic             perf_clr;

  logic             exe_valid;
  logic [XLEN-1:0]  exe_pc;
  logic [UOP_W-1:0] exe_uop;
  logic [XLEN-1:0]  exe_imm;
  logic [4:0]       exe_rd;
  logic             exe_rd_wenb;
  logic             exe_load;
  logic             exe_csr;
  logic [XLEN-1:0]  exe_rs1_data;
  logic [XLEN-1:0]  exe_rs2_data;
  logic             dec_hold;
  logic [CNT_W-1:0] perf_issue_cnt;
  logic [CNT_W-1:0] perf_bubble_cnt;
  logic [CNT_W-1:0] perf_load_use_cnt;
  logic [CNT_W-1:0] perf_csr_use_cnt;

  // Pipeline register side.
  modport slave (
    input  dec_valid, dec_pc, dec_uop, dec_imm, dec_rd, dec_rd_wenb, dec_load,
           dec_csr, dec_rs1_data, dec_rs2_data, dec_stall, dec_load_use,
           dec_csr_use, exe_flush, exe_hold, perf_clr,
    output exe_valid, exe_pc, exe_uop, exe_imm, exe_rd, exe_rd_wenb, exe_load,
           exe_csr, exe_rs1_data, exe_rs2_data, dec_hold, perf_issue_cnt,
           perf_bubble_cnt, perf_load_use_cnt, perf_csr_use_cnt
  );

  // Core-control side driving DEC fields and observing EXE.
  modport master (
    output dec_valid, dec_pc, dec_uop, dec_imm, dec_rd, dec_rd_wenb, dec_load,
           dec_csr, dec_rs1_data, dec_rs2_data, dec_stall, dec_load_use,
           dec_csr_use, exe_flush, exe_hold, perf_clr,
    input  exe_valid, exe_pc, exe_uop, exe_imm, exe_rd, exe_rd_wenb, exe_load,
           exe_csr, exe_rs1_data, exe_rs2_data, dec_hold, perf_issue_cnt,
           perf_bubble_cnt, perf_load_use_cnt, perf_csr_use_cnt
  );
endinterface

// File: rtl/dec_exe_pipe_perf_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/dec_exe_pipe.sv
// DEC-to-EXE pipeline register: captures one decoded instruction per cycle,
// inserts bubbles on stall/flush, freezes on EXE hold, counts issue/stall events.
module dec_exe_pipe
  import dec_exe_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int UOP_W = UOP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  dec_exe_pipe_if.slave bus
);
  pipe_act_e        w_act;
  logic             w_load_bubble;
  logic             w_issue_inc;
  logic             w_bubble_inc;

  logic             r_valid_p1;
  logic [XLEN-1:0]  r_pc_p1;
  logic [UOP_W-1:0] r_uop_p1;
  logic [XLEN-1:0]  r_imm_p1;
  logic [4:0]       r_rd_p1;
  logic             r_rd_wenb_p1;
  logic             r_load_p1;
  logic             r_csr_p1;
  logic [XLEN-1:0]  r_rs1_p1;
  logic [XLEN-1:0]  r_rs2_p1;

  assign w_act         = pick_action(bus.exe_hold, bus.exe_flush, bus.dec_stall);
  assign w_load_bubble = reset || (w_act == ACT_FLUSH) || (w_act == ACT_STALL);
  // A stall under a flush is not counted: the flush already killed that slot.
  assign w_issue_inc   = (w_act == ACT_CAPTURE) && bus.dec_valid;
  assign w_bubble_inc  = (w_act == ACT_STALL) && bus.dec_valid;

  // DEC -> EXE stage boundary: bubble, freeze or capture.
  always_ff @(posedge clk) begin
    if (w_load_bubble) begin
      r_valid_p1   <= 1'b0;
      r_pc_p1      <= '0;
      r_uop_p1     <= UOP_W'(UOP_BUBBLE);
      r_imm_p1     <= '0;
      r_rd_p1      <= REG_X0;
      r_rd_wenb_p1 <= 1'b0;
      r_load_p1    <= 1'b0;
      r_csr_p1     <= 1'b0;
      r_rs1_p1     <= '0;
      r_rs2_p1     <= '0;
    end else if (w_act == ACT_CAPTURE) begin
      r_valid_p1   <= bus.dec_valid;
      r_pc_p1      <= bus.dec_pc;
      r_uop_p1     <= bus.dec_uop;
      r_imm_p1     <= bus.dec_imm;
      r_rd_p1      <= bus.dec_rd;
      // Gate side-effect flags so an invalid slot never looks like a writer.
      r_rd_wenb_p1 <= bus.dec_rd_wenb && bus.dec_valid;
      r_load_p1    <= bus.dec_load && bus.dec_valid;
      r_csr_p1     <= bus.dec_csr && bus.dec_valid;
      r_rs1_p1     <= bus.dec_rs1_data;
      r_rs2_p1     <= bus.dec_rs2_data;
    end
  end

  assign bus.exe_valid    = r_valid_p1;
  assign bus.exe_pc       = r_pc_p1;
  assign bus.exe_uop      = r_uop_p1;
  assign bus.exe_imm      = r_imm_p1;
  assign bus.exe_rd       = r_rd_p1;
  assign bus.exe_rd_wenb  = r_rd_wenb_p1;
  assign bus.exe_load     = r_load_p1;
  assign bus.exe_csr      = r_csr_p1;
  assign bus.exe_rs1_data = r_rs1_p1;
  assign bus.exe_rs2_data = r_rs2_p1;
  assign bus.dec_hold     = bus.exe_hold;

  perf_sat_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk(clk), .reset(reset), .i_inc(w_issue_inc), .i_clr(bus.perf_clr),
    .o_cnt(bus.perf_issue_cnt));

  perf_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset(reset), .i_inc(w_bubble_inc), .i_clr(bus.perf_clr),
    .o_cnt(bus.perf_bubble_cnt));

  perf_sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk(clk), .reset(reset), .i_inc(w_bubble_inc && bus.dec_load_use),
    .i_clr(bus.perf_clr), .o_cnt(bus.perf_load_use_cnt));

  perf_sat_counter #(.CNT_W(CNT_W)) u_csr_use_cnt (
    .clk(clk), .reset(reset), .i_inc(w_bubble_inc && bus.dec_csr_use),
    .i_clr(bus.perf_clr), .o_cnt(bus.perf_csr_use_cnt));
endmodule

// File: tb/tb_dec_exe_pipe.sv
// Bench for dec_exe_pipe: directed scenarios plus randomized traffic
// against a cycle-level reference model; a 4-bit-counter instance for saturation.
module tb_dec_exe_pipe;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dec_exe_pipe_if #(.XLEN(32), .UOP_W(16), .CNT_W(32)) bus ();
  dec_exe_pipe_if #(.XLEN(32), .UOP_W(16), .CNT_W(4))  bus4 ();

  dec_exe_pipe #(.XLEN(32), .UOP_W(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  dec_exe_pipe #(.XLEN(32), .UOP_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flush and hold together is illegal upstream behaviour.
  assert property (@(posedge clk) disable iff (reset) !(bus.exe_flush && bus.exe_hold))
    else $error("exe_flush and exe_hold asserted together");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_pc = 0; bus.dec_uop = 0; bus.dec_imm = 0;
    bus.dec_rd = 0; bus.dec_rd_wenb = 0; bus.dec_load = 0; bus.dec_csr = 0;
    bus.dec_rs1_data = 0; bus.dec_rs2_data = 0; bus.dec_stall = 0;
    bus.dec_load_use = 0; bus.dec_csr_use = 0; bus.exe_flush = 0;
    bus.exe_hold = 0; bus.perf_clr = 0;
  endtask

  task automatic idle4();
    bus4.dec_valid = 0; bus4.dec_pc = 0; bus4.dec_uop = 0; bus4.dec_imm = 0;
    bus4.dec_rd = 0; bus4.dec_rd_wenb = 0; bus4.dec_load = 0; bus4.dec_csr = 0;
    bus4.dec_rs1_data = 0; bus4.dec_rs2_data = 0; bus4.dec_stall = 0;
    bus4.dec_load_use = 0; bus4.dec_csr_use = 0; bus4.exe_flush = 0;
    bus4.exe_hold = 0; bus4.perf_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    bus.dec_valid = 1; bus.dec_pc = 32'h55; bus.dec_rd_wenb = 1; bus.dec_load = 1;
    reset = 1;
    tick(); tick();
    n_tests++; if (bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", bus.exe_valid); end
    n_tests++; if (bus.exe_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", bus.exe_pc); end
    n_tests++; if (bus.exe_rd_wenb !== 1'b0 || bus.exe_load !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0b%0b want 00", bus.exe_rd_wenb, bus.exe_load); end
    n_tests++; if (bus.perf_issue_cnt !== 32'h0 || bus.perf_bubble_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0h/%0h want 0/0", bus.perf_issue_cnt, bus.perf_bubble_cnt); end
    idle();
    reset = 0;
  endtask

  task automatic test_capture();
    bus.dec_valid = 1; bus.dec_pc = 32'h100; bus.dec_rd = 5; bus.dec_rd_wenb = 1;
    bus.dec_rs1_data = 32'hDEADBEEF;
    tick();
    n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %0h want 1", bus.exe_valid); end
    n_tests++; if (bus.exe_pc !== 32'h100) begin n_fail++; $display("FAIL cap_pc got %0h want 100", bus.exe_pc); end
    n_tests++; if (bus.exe_rd !== 5'd5 || bus.exe_rd_wenb !== 1'b1) begin n_fail++; $display("FAIL cap_rd got %0d/%0b want 5/1", bus.exe_rd, bus.exe_rd_wenb); end
    n_tests++; if (bus.exe_rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cap_rs1 got %0h want deadbeef", bus.exe_rs1_data); end
    n_tests++; if (bus.perf_issue_cnt !== 32'd1) begin n_fail++; $display("FAIL cap_issue got %0d want 1", bus.perf_issue_cnt); end
    idle();
  endtask

  task automatic test_stall();
    idle();
    bus.dec_valid = 1; bus.dec_stall = 1; bus.dec_load_use = 1;
    bus.dec_rd_wenb = 1; bus.dec_load = 1; bus.dec_pc = 32'h140;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (bus.exe_valid !== 1'b0 || bus.exe_rd_wenb !== 1'b0 || bus.exe_load !== 1'b0) begin n_fail++; $display("FAIL stall_bubble%0d got %0b%0b%0b want 000", i, bus.exe_valid, bus.exe_rd_wenb, bus.exe_load); end
    end
    n_tests++; if (bus.perf_bubble_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_bubble_cnt got %0d want 2", bus.perf_bubble_cnt); end
    n_tests++; if (bus.perf_load_use_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_lu_cnt got %0d want 2", bus.perf_load_use_cnt); end
    n_tests++; if (bus.perf_csr_use_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_cu_cnt got %0d want 0", bus.perf_csr_use_cnt); end
    n_tests++; if (bus.perf_issue_cnt !== 32'd1) begin n_fail++; $display("FAIL stall_issue got %0d want 1", bus.perf_issue_cnt); end
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] b0, c0;
    bus.dec_valid = 1; bus.dec_pc = 32'h180; bus.dec_rd = 9; bus.dec_rd_wenb = 1;
    tick();
    b0 = bus.perf_bubble_cnt; c0 = bus.perf_csr_use_cnt;
    bus.exe_flush = 1; bus.dec_stall = 1; bus.dec_csr_use = 1; bus.dec_csr = 1;
    tick();
    n_tests++; if (bus.exe_valid !== 1'b0 || bus.exe_pc !== 32'h0 || bus.exe_rd !== 5'd0) begin n_fail++; $display("FAIL flush_bubble got v%0b pc%0h rd%0d want 0/0/0", bus.exe_valid, bus.exe_pc, bus.exe_rd); end
    n_tests++; if (bus.exe_rd_wenb !== 1'b0 || bus.exe_csr !== 1'b0) begin n_fail++; $display("FAIL flush_flags got %0b%0b want 00", bus.exe_rd_wenb, bus.exe_csr); end
    n_tests++; if (bus.perf_bubble_cnt !== b0 || bus.perf_csr_use_cnt !== c0) begin n_fail++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", bus.perf_bubble_cnt, bus.perf_csr_use_cnt, b0, c0); end
    idle();
  endtask

  task automatic test_hold();
    logic [31:0] iss0, bub0;
    bus.dec_valid = 1; bus.dec_pc = 32'h1F0; bus.dec_rd = 7; bus.dec_rd_wenb = 1;
    tick();
    iss0 = bus.perf_issue_cnt; bub0 = bus.perf_bubble_cnt;
    bus.exe_hold = 1;
    for (int i = 0; i < 3; i++) begin
      bus.dec_pc = 32'h200 + 32'(4 * i);
      bus.dec_stall = (i == 1);
      tick();
      n_tests++; if (bus.exe_pc !== 32'h1F0 || bus.exe_rd !== 5'd7 || bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL hold_frozen%0d got pc%0h rd%0d want 1f0/7", i, bus.exe_pc, bus.exe_rd); end
      n_tests++; if (bus.dec_hold !== 1'b1) begin n_fail++; $display("FAIL hold_dec_hold%0d got %0b want 1", i, bus.dec_hold); end
      n_tests++; if (bus.perf_issue_cnt !== iss0 || bus.perf_bubble_cnt !== bub0) begin n_fail++; $display("FAIL hold_cnt%0d got %0d/%0d want %0d/%0d", i, bus.perf_issue_cnt, bus.perf_bubble_cnt, iss0, bub0); end
    end
    bus.exe_hold = 0; bus.dec_stall = 0;
    tick();
    n_tests++; if (bus.exe_pc !== 32'h208 || bus.dec_hold !== 1'b0) begin n_fail++; $display("FAIL hold_release got pc%0h hold%0b want 208/0", bus.exe_pc, bus.dec_hold); end
    n_tests++; if (bus.perf_issue_cnt !== iss0 + 1) begin n_fail++; $display("FAIL hold_release_issue got %0d want %0d", bus.perf_issue_cnt, iss0 + 1); end
    idle();
  endtask

  task automatic test_invalid();
    logic [31:0] iss0;
    tick();
    iss0 = bus.perf_issue_cnt;
    bus.dec_valid = 0; bus.dec_rd_wenb = 1; bus.dec_load = 1; bus.dec_csr = 1;
    bus.dec_rd = 12; bus.dec_pc = 32'h300;
    tick();
    n_tests++; if (bus.exe_rd_wenb !== 1'b0 || bus.exe_load !== 1'b0 || bus.exe_csr !== 1'b0) begin n_fail++; $display("FAIL inv_flags got %0b%0b%0b want 000", bus.exe_rd_wenb, bus.exe_load, bus.exe_csr); end
    n_tests++; if (bus.exe_valid !== 1'b0 || bus.exe_pc !== 32'h300) begin n_fail++; $display("FAIL inv_fields got v%0b pc%0h want 0/300", bus.exe_valid, bus.exe_pc); end
    n_tests++; if (bus.perf_issue_cnt !== iss0) begin n_fail++; $display("FAIL inv_issue got %0d want %0d", bus.perf_issue_cnt, iss0); end
    idle();
  endtask

  task automatic test_reset_mid_hold();
    bus.dec_valid = 1; bus.dec_pc = 32'h400; tick();
    bus.exe_hold = 1; bus.dec_stall = 1; reset = 1;
    tick();
    n_tests++; if (bus.exe_valid !== 1'b0 || bus.exe_pc !== 32'h0) begin n_fail++; $display("FAIL rst_hold got v%0b pc%0h want 0/0", bus.exe_valid, bus.exe_pc); end
    n_tests++; if (bus.perf_issue_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_hold_cnt got %0d want 0", bus.perf_issue_cnt); end
    reset = 0; idle();
  endtask

  task automatic test_saturate();
    idle4();
    bus4.dec_valid = 1; bus4.dec_stall = 1; bus4.dec_load_use = 1;
    repeat (16) tick();
    n_tests++; if (bus4.perf_bubble_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_bubble got %0d want 15", bus4.perf_bubble_cnt); end
    n_tests++; if (bus4.perf_load_use_cnt !== 4'hF || bus4.perf_issue_cnt !== 4'h0) begin n_fail++; $display("FAIL sat_other got %0d/%0d want 15/0", bus4.perf_load_use_cnt, bus4.perf_issue_cnt); end
    bus4.perf_clr = 1;
    tick();
    n_tests++; if (bus4.perf_bubble_cnt !== 4'h0 || bus4.perf_load_use_cnt !== 4'h0) begin n_fail++; $display("FAIL sat_clr got %0d/%0d want 0/0", bus4.perf_bubble_cnt, bus4.perf_load_use_cnt); end
    bus4.perf_clr = 0;
    tick();
    n_tests++; if (bus4.perf_bubble_cnt !== 4'h1) begin n_fail++; $display("FAIL sat_after_clr got %0d want 1", bus4.perf_bubble_cnt); end
    idle4();
  endtask

  // Reference model: expected EXE view and counters after each edge.
  task automatic test_random();
    logic        m_valid, m_wenb, m_load, m_csr;
    logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [15:0] m_uop;
    logic [4:0]  m_rd;
    logic [31:0] m_iss, m_bub, m_lu, m_cu;
    int          sel;
    reset = 1; idle(); tick(); reset = 0;
    {m_valid, m_wenb, m_load, m_csr} = '0;
    m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_uop = 0; m_rd = 0;
    m_iss = 0; m_bub = 0; m_lu = 0; m_cu = 0;
    for (int n = 0; n < 400; n++) begin
      bus.dec_valid = 1'($urandom_range(0, 3) != 0);
      bus.dec_pc = $urandom; bus.dec_uop = 16'($urandom); bus.dec_imm = $urandom;
      bus.dec_rd = 5'($urandom); bus.dec_rd_wenb = 1'($urandom);
      bus.dec_load = 1'($urandom); bus.dec_csr = 1'($urandom);
      bus.dec_rs1_data = $urandom; bus.dec_rs2_data = $urandom;
      bus.dec_stall = 1'($urandom_range(0, 3) == 0);
      bus.dec_load_use = 1'($urandom); bus.dec_csr_use = 1'($urandom);
      sel = $urandom_range(0, 7);
      bus.exe_flush = (sel == 0); bus.exe_hold = (sel == 1);
      bus.perf_clr = 1'($urandom_range(0, 31) == 0);
      reset = 1'($urandom_range(0, 63) == 0);
      if (reset || (!bus.exe_hold && (bus.exe_flush || bus.dec_stall))) begin
        {m_valid, m_wenb, m_load, m_csr} = '0;
        m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_uop = 0; m_rd = 0;
      end else if (!bus.exe_hold) begin
        m_valid = bus.dec_valid; m_pc = bus.dec_pc; m_uop = bus.dec_uop;
        m_imm = bus.dec_imm; m_rd = bus.dec_rd; m_rs1 = bus.dec_rs1_data;
        m_rs2 = bus.dec_rs2_data;
        m_wenb = bus.dec_valid & bus.dec_rd_wenb;
        m_load = bus.dec_valid & bus.dec_load;
        m_csr  = bus.dec_valid & bus.dec_csr;
      end
      if (reset || bus.perf_clr) begin
        m_iss = 0; m_bub = 0; m_lu = 0; m_cu = 0;
      end else if (!bus.exe_hold && !bus.exe_flush && bus.dec_valid) begin
        if (!bus.dec_stall) begin
          if (m_iss != 32'hFFFF_FFFF) m_iss++;
        end else begin
          if (m_bub != 32'hFFFF_FFFF) m_bub++;
          if (bus.dec_load_use && m_lu != 32'hFFFF_FFFF) m_lu++;
          if (bus.dec_csr_use && m_cu != 32'hFFFF_FFFF) m_cu++;
        end
      end
      tick();
      reset = 0;
      n_tests++; if ({bus.exe_valid, bus.exe_rd_wenb, bus.exe_load, bus.exe_csr} !== {m_valid, m_wenb, m_load, m_csr}) begin n_fail++; $display("FAIL rnd%0d_flags got %04b want %04b", n, {bus.exe_valid, bus.exe_rd_wenb, bus.exe_load, bus.exe_csr}, {m_valid, m_wenb, m_load, m_csr}); end
      n_tests++; if (bus.exe_pc !== m_pc || bus.exe_rd !== m_rd || bus.exe_uop !== m_uop) begin n_fail++; $display("FAIL rnd%0d_ctl got %0h/%0d/%0h want %0h/%0d/%0h", n, bus.exe_pc, bus.exe_rd, bus.exe_uop, m_pc, m_rd, m_uop); end
      n_tests++; if (bus.exe_imm !== m_imm || bus.exe_rs1_data !== m_rs1 || bus.exe_rs2_data !== m_rs2) begin n_fail++; $display("FAIL rnd%0d_data got %0h/%0h/%0h want %0h/%0h/%0h", n, bus.exe_imm, bus.exe_rs1_data, bus.exe_rs2_data, m_imm, m_rs1, m_rs2); end
      n_tests++; if (bus.perf_issue_cnt !== m_iss || bus.perf_bubble_cnt !== m_bub) begin n_fail++; $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", n, bus.perf_issue_cnt, bus.perf_bubble_cnt, m_iss, m_bub); end
      n_tests++; if (bus.perf_load_use_cnt !== m_lu || bus.perf_csr_use_cnt !== m_cu) begin n_fail++; $display("FAIL rnd%0d_cause got %0d/%0d want %0d/%0d", n, bus.perf_load_use_cnt, bus.perf_csr_use_cnt, m_lu, m_cu); end
    end
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1;
    idle();
    idle4();
    test_reset();
    test_capture();
    test_stall();
    test_flush();
    test_hold();
    test_invalid();
    test_reset_mid_hold();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dec_exe_pipe.md
Name: dec_exe_pipe

Overview:
DEC-to-EXE pipeline register for the 5-stage RISC-V core. Consumes the bypass/stall unit's outputs (forwarded operands, stall, load-use/CSR-use causes) plus DEC control fields, and presents one registered instruction to EXE each cycle. Inserts bubbles on DEC stall or EXE flush and freezes under EXE back-pressure. Keeps saturating performance counters for issue and stall events.

Parameters:
XLEN, 32, datapath width
UOP_W, 16, width of opaque decoded control bundle passed to EXE
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
dec_valid  in  1  DEC holds a real instruction
dec_pc  in  XLEN  DEC instruction PC
dec_uop  in  UOP_W  decoded control bundle
dec_imm  in  XLEN  decoded immediate
dec_rd  in  5  destination register
dec_rd_wenb  in  1  instruction writes rd
dec_load  in  1  instruction is a load
dec_csr  in  1  instruction is CSRRx
dec_rs1_data  in  XLEN  forwarded R[rs1]
dec_rs2_data  in  XLEN  forwarded R[rs2]
dec_stall  in  1  bypass unit requests DEC stall
dec_load_use  in  1  stall cause: load-use
dec_csr_use  in  1  stall cause: CSR-use
exe_flush  in  1  EXE resolved a redirect; kill DEC instruction
exe_hold  in  1  EXE busy (multi-cycle op); freeze this register
perf_clr  in  1  synchronous clear of all counters
exe_valid  out  1  EXE holds a real instruction
exe_pc  out  XLEN
exe_uop  out  UOP_W
exe_imm  out  XLEN
exe_rd  out  5
exe_rd_wenb  out  1  gated by exe_valid; drives bypass unit
exe_load  out  1  gated by exe_valid
exe_csr  out  1  gated by exe_valid
exe_rs1_data  out  XLEN
exe_rs2_data  out  XLEN
dec_hold  out  1  DEC/IF must not advance (= exe_hold, combinational)
perf_issue_cnt  out  CNT_W  valid instructions passed to EXE
perf_bubble_cnt  out  CNT_W  stall bubbles inserted
perf_load_use_cnt  out  CNT_W  bubbles caused by load-use
perf_csr_use_cnt  out  CNT_W  bubbles caused by CSR-use

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs and counters 0; EXE holds a bubble.
- Latency: 1 cycle DEC to EXE. All updates on rising clk. Per-cycle priority: reset > exe_hold > exe_flush > dec_stall > capture.
- exe_hold=1: all exe_* registers keep value; counters unchanged; dec_hold=1.
- exe_flush=1 (hold=0): load bubble: exe_valid, exe_rd_wenb, exe_load, exe_csr = 0; exe_rd=0; data/uop/pc fields = 0. Overrides a simultaneous dec_stall; that stall is not counted.
- dec_stall=1 (hold=0, flush=0): load bubble as above. If dec_valid=1: bubble_cnt+1, plus load_use_cnt+1 if dec_load_use, csr_use_cnt+1 if dec_csr_use (both may increment in one cycle).
- Capture: all dec_* fields registered; exe_valid=dec_valid; exe_rd_wenb/exe_load/exe_csr ANDed with dec_valid; if dec_valid, issue_cnt+1.
- Bubble must never drive exe_rd_wenb=1 or exe_load=1: prevents false forwarding and false load-use stall in the bypass unit.
- Counters saturate at all-ones; perf_clr zeroes them next cycle and beats any same-cycle increment.
- exe_flush and exe_hold asserted together is a protocol violation: hold wins; verification flags it with an assertion.
- Reset mid-hold or mid-stall: reset wins, bubble next cycle.

Decomposition:
- Shared cpu_pkg: XLEN, UOP_W, CNT_W defaults; bubble constant for uop bundle (all zero); RISC-V x0 index.
- One sub-module: perf_sat_counter (CNT_W, inc, clr, synchronous reset, saturating), instantiated four times.

Test Plan:
- Reset then dec_valid=1, pc=0x100, rd=5, wenb=1, rs1_data=0xDEADBEEF -> next cycle exe_valid=1, exe_pc=0x100, exe_rd=5, exe_rs1_data=0xDEADBEEF, issue_cnt=1.
- dec_stall=1, dec_load_use=1, dec_valid=1 for 2 cycles -> exe_valid=0, exe_rd_wenb=0, exe_load=0 both cycles; bubble_cnt=2, load_use_cnt=2, csr_use_cnt=0.
- exe_flush=1 with dec_stall=1, dec_csr_use=1 -> bubble captured; bubble_cnt and csr_use_cnt unchanged.
- exe_hold=1 for 3 cycles while dec fields change (pc 0x200..0x208) -> exe_* stays at prior instruction; dec_hold=1; counters frozen; after release, 0x208 captured.
- dec_valid=0, dec_rd_wenb=1, dec_load=1 -> exe_rd_wenb=0, exe_load=0, issue_cnt unchanged.
- CNT_W=4: 16 stall cycles -> bubble_cnt=15 (saturated); perf_clr with dec_stall=1 -> 0 next cycle.
